// File: rtl/dadda8_pkg.sv
// dadda8_pkg: shared state encoding and default widths for the dot-product engine
package dadda8_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
   localparam int ACC_W_DEF = 24;
   localparam int LEN_W_DEF = 8;
endpackage

// File: rtl/dadda8_orig.sv
// dadda8_orig: 8x8 unsigned Dadda multiplier (column reduction to heights 6,4,3,2 then a final add)
module dadda8_orig (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] out
);
   logic [15:0] col [16];
   logic [15:0] nxt [16];
   logic [3:0]  h [16];
   logic [3:0]  nh [16];
   logic [3:0]  d, k, r;
   logic        s_b, c_b;
   logic [15:0] r0, r1;
   always_comb begin
      col = '{default: '0};
      nxt = '{default: '0};
      h = '{default: '0};
      nh = '{default: '0};
      d = '0;
      k = '0;
      r = '0;
      s_b = 1'b0;
      c_b = 1'b0;
      r0 = '0;
      r1 = '0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            col[i+j][h[i+j]] = a[i] & b[j];
            h[i+j] = h[i+j] + 4'd1;
         end
      for (int s = 0; s < 4; s++) begin
         d = s == 0 ? 4'd6 : s == 1 ? 4'd4 : s == 2 ? 4'd3 : 4'd2;
         nxt = '{default: '0};
         nh = '{default: '0};
         for (int i = 0; i < 16; i++) begin
            k = '0;
            r = h[i] + nh[i];
            for (int t = 0; t < 4; t++)
               if (r > d) begin
                  if (r == d + 4'd1) begin
                     s_b = col[i][k] ^ col[i][k+4'd1];
                     c_b = col[i][k] & col[i][k+4'd1];
                     k = k + 4'd2;
                     r = r - 4'd1;
                  end else begin
                     s_b = col[i][k] ^ col[i][k+4'd1] ^ col[i][k+4'd2];
                     c_b = (col[i][k] & col[i][k+4'd1]) | (col[i][k] & col[i][k+4'd2]) | (col[i][k+4'd1] & col[i][k+4'd2]);
                     k = k + 4'd3;
                     r = r - 4'd2;
                  end
                  nxt[i][nh[i]] = s_b;
                  nh[i] = nh[i] + 4'd1;
                  if (i < 15) begin
                     nxt[i+1][nh[i+1]] = c_b;
                     nh[i+1] = nh[i+1] + 4'd1;
                  end
               end
            for (int t = 0; t < 16; t++)
               if (4'(t) >= k && 4'(t) < h[i]) begin
                  nxt[i][nh[i]] = col[i][t];
                  nh[i] = nh[i] + 4'd1;
               end
         end
         col = nxt;
         h = nh;
      end
      for (int i = 0; i < 16; i++) begin
         r0[i] = col[i][0];
         r1[i] = col[i][1];
      end
      out = r0 + r1;
   end
endmodule

// File: rtl/dadda8_dot_acc.sv
// dadda8_dot_acc: streams len operand pairs through the Dadda multiplier and emits their accumulated sum
module dadda8_dot_acc
   import dadda8_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] result,
   output logic             overflow,
   output logic             busy
);
   state_t           state, state_n;
   logic [LEN_W-1:0] remaining;
   logic [15:0]      prod, prod_q;
   logic             prod_v;
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;
   logic             accept;
   dadda8_orig u_mul (.a(a), .b(b), .out(prod));
   assign in_ready  = state == LOAD;
   assign out_valid = state == DONE;
   assign busy      = state != IDLE;
   assign result    = acc;
   assign accept    = in_valid & in_ready;
   assign sum       = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod_q};
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    state_n = start ? (len != '0 ? LOAD : DONE) : IDLE;
         LOAD:    state_n = accept && remaining == LEN_W'(1) ? DRAIN : LOAD;
         DRAIN:   state_n = DONE;
         DONE:    state_n = out_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= '0;
         prod_q    <= '0;
         prod_v    <= 1'b0;
         acc       <= '0;
         overflow  <= 1'b0;
      end else begin
         state  <= state_n;
         prod_v <= accept;
         if (accept) begin
            prod_q    <= prod;
            remaining <= remaining - LEN_W'(1);
         end
         if (state == IDLE && start) begin
            remaining <= len;
            acc       <= '0;
            overflow  <= 1'b0;
         end else if (prod_v) begin
            acc      <= sum[ACC_W-1:0];
            overflow <= overflow | sum[ACC_W];
         end
      end
   end
endmodule

// File: tb/tb_dadda8_dot_acc.sv
// tb_dadda8_dot_acc: directed and random runs against a scoreboard of expected sums
module tb_dadda8_dot_acc;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, overflow, busy;
   logic [23:0] result;
   logic        in_ready16, out_valid16, overflow16, busy16;
   logic [15:0] result16;
   int          tests = 0;
   int          fails = 0;
   int          q[$];
   int          e_sum;
   logic [7:0]  xa [12];
   logic [7:0]  xb [12];

   dadda8_dot_acc dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .overflow(overflow), .busy(busy)
   );
   dadda8_dot_acc #(.ACC_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready16),
      .a(a), .b(b), .out_valid(out_valid16), .out_ready(out_ready), .result(result16),
      .overflow(overflow16), .busy(busy16)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got %0d expected no output at %0t", result, $time);
         end else begin
            e_sum = q[0];
            chk("result", {8'd0, result}, {8'd0, e_sum[23:0]});
            chk("overflow", {31'd0, overflow}, {31'd0, e_sum > 32'hFFFFFF});
            chk("result16", {16'd0, result16}, {16'd0, e_sum[15:0]});
            chk("overflow16", {31'd0, overflow16}, {31'd0, e_sum > 65535});
            chk("out_valid16", {31'd0, out_valid16}, 32'd1);
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   task automatic start_run(input logic [7:0] n);
      len = n;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic sp);
      int n = 0;
      a = x;
      b = y;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 20) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      start = sp;
      @(posedge clk); #1;
      in_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic finish_run(input int hold, input logic sp);
      int n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 50) chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
      repeat (hold) begin
         start = sp;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      start = sp;
      @(posedge clk); #1;
      out_ready = 1'b0;
      start = 1'b0;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, sum, g;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", {8'd0, result}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_run(8'd5);
      send(8'd9, 8'd9, 1'b0);
      send(8'd8, 8'd8, 1'b0);
      send(8'd7, 8'd7, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_result", {8'd0, result}, 32'd0);
      chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      q.push_back(12);
      start_run(8'd1);
      send(8'd3, 8'd4, 1'b0);
      finish_run(0, 1'b0);
      q.push_back(260100);
      start_run(8'd4);
      repeat (4) send(8'd255, 8'd255, 1'b0);
      chk("lat_drain_out_valid", {31'd0, out_valid}, 32'd0);
      chk("lat_drain_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("lat_done_out_valid", {31'd0, out_valid}, 32'd1);
      finish_run(0, 1'b0);
      q.push_back(264);
      start_run(8'd3);
      send(8'd10, 8'd20, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      send(8'd7, 8'd9, 1'b0);
      send(8'd1, 8'd1, 1'b0);
      finish_run(5, 1'b0);
      q.push_back(0);
      chk("zero_in_ready_before", {31'd0, in_ready}, 32'd0);
      start_run(8'd0);
      chk("zero_out_valid", {31'd0, out_valid}, 32'd1);
      chk("zero_in_ready", {31'd0, in_ready}, 32'd0);
      finish_run(0, 1'b0);
      q.push_back(130050);
      start_run(8'd2);
      send(8'd255, 8'd255, 1'b0);
      send(8'd255, 8'd255, 1'b0);
      finish_run(1, 1'b1);
      for (int r = 0; r < 1000; r++) begin
         n = $urandom_range(0, 12);
         sum = 0;
         for (int i = 0; i < 12; i++) begin
            xa[i] = 8'($urandom_range(0, 255));
            xb[i] = 8'($urandom_range(0, 255));
            if (i < n) sum += int'(xa[i]) * int'(xb[i]);
         end
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b1;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            in_valid = 1'b0;
         end
         q.push_back(sum);
         start_run(8'(n));
         for (int i = 0; i < n; i++) begin
            g = $urandom_range(0, 3);
            if (g > 1) repeat (g - 1) @(posedge clk);
            if (g > 1) #1;
            send(xa[i], xb[i], 1'($urandom_range(0, 1)));
         end
         finish_run($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      chk("queue_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
